// File: rtl/writeback_multi.sv
// writeback_multi: multi-lane writeback stage.
// Takes bundles of up to NLANES completed instructions from the memory stage
// through a valid/ready handshake and queues them in a DEPTH-entry FIFO. It
// drains the head bundle into a register file with NPORTS write ports, in
// lane order, and retires up to NPORTS slots per cycle.
// Optional feature: define WB_INSTRET_EN to add a 64-bit instret output that
// accumulates retire_cnt.
module writeback_multi #(
  parameter int NLANES = 2,
  parameter int NPORTS = 1,
  parameter int DEPTH  = 2,
  parameter int XLEN   = 64,
  parameter int AW     = 5
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NLANES-1:0]           in_slot_valid,
  input  logic [NLANES-1:0]           in_regwrite,
  input  logic [NLANES*AW-1:0]        in_wa,
  input  logic [NLANES*XLEN-1:0]      in_result,
  output logic [NPORTS-1:0]           rf_we,
  output logic [NPORTS*AW-1:0]        rf_wa,
  output logic [NPORTS*XLEN-1:0]      rf_wd,
  output logic [$clog2(NLANES+1)-1:0] retire_cnt,
`ifdef WB_INSTRET_EN
  output logic [63:0]                 instret,
`endif
  output logic                        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(NLANES + 1);

  // IDLE: FIFO empty. LOAD: head present, pending mask taken from the head's
  // slot_valid. DRAIN: head partly retired, pending mask held in pending_q.
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN
  } state_e;

  // Bundle storage
  logic [NLANES-1:0]      mem_sv_q [DEPTH];
  logic [NLANES-1:0]      mem_rw_q [DEPTH];
  logic [NLANES*AW-1:0]   mem_wa_q [DEPTH];
  logic [NLANES*XLEN-1:0] mem_wd_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [NLANES-1:0] pending_q, pending_d;
  state_e            state_q, state_d;

  logic              push;
  logic              pop;
  logic [NLANES-1:0] head_mask;
  logic [NLANES-1:0] head_rw;
  logic [NLANES*AW-1:0]   head_wa;
  logic [NLANES*XLEN-1:0] head_wd;
  logic [NLANES-1:0] sel;
  logic [NLANES-1:0] remaining;
  int unsigned       k;

  // Ready depends only on the registered count, never on this cycle's drain.
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign empty    = (count_q == '0);

  assign head_rw = mem_rw_q[rd_ptr_q];
  assign head_wa = mem_wa_q[rd_ptr_q];
  assign head_wd = mem_wd_q[rd_ptr_q];

  // Bundle storage write on accept
  // NOTE: the FIFO array has no reset; its contents are only read behind a
  // non-zero count, so clearing it would cost logic and buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sv_q[wr_ptr_q] <= in_slot_valid;
      mem_rw_q[wr_ptr_q] <= in_regwrite;
      mem_wa_q[wr_ptr_q] <= in_wa;
      mem_wd_q[wr_ptr_q] <= in_result;
    end
  end

  // Slot selection, port mapping, pop decision and next-state logic
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred; blocking '='
    // is correct here because the loop reads values written earlier in it.
    rf_we      = '0;
    rf_wa      = '0;
    rf_wd      = '0;
    retire_cnt = '0;
    sel        = '0;
    k          = 0;
    pop        = 1'b0;
    state_d    = state_q;
    pending_d  = pending_q;
    head_mask  = (state_q == S_DRAIN) ? pending_q : mem_sv_q[rd_ptr_q];
    remaining  = '0;

    if (state_q != S_IDLE) begin
      // Lowest-index pending slots go to ports 0..k-1 in lane order.
      for (int i = 0; i < NLANES; i++) begin
        if (head_mask[i] && (k < NPORTS)) begin
          sel[i]               = 1'b1;
          rf_we[k]             = head_rw[i] && (head_wa[i*AW +: AW] != '0);
          rf_wa[k*AW +: AW]    = head_wa[i*AW +: AW];
          rf_wd[k*XLEN +: XLEN] = head_wd[i*XLEN +: XLEN];
          k                    = k + 1;
        end
      end
      retire_cnt = RW'(k);

      // Same-address writes in one cycle: the higher lane (higher port) wins.
      for (int j = 0; j < NPORTS; j++) begin
        for (int m = j + 1; m < NPORTS; m++) begin
          if (rf_we[j] && rf_we[m] && (rf_wa[j*AW +: AW] == rf_wa[m*AW +: AW]))
            rf_we[j] = 1'b0;
        end
      end

      remaining = head_mask & ~sel;
      if (remaining == '0) begin
        pop       = 1'b1;
        pending_d = '0;
      end else begin
        pending_d = remaining;
        state_d   = S_DRAIN;
      end
    end

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    // Popping loads the next head in the same cycle, so bundles drain
    // back-to-back without a bubble.
    if (state_q == S_IDLE || pop)
      state_d = (count_d != '0) ? S_LOAD : S_IDLE;
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      state_q   <= S_IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      state_q   <= state_d;
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // Retired-instruction counter, wraps at 2^64
  always_ff @(posedge clk) begin
    if (!resetn) instret_q <= '0;
    else         instret_q <= instret_q + 64'(retire_cnt);
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_multi.sv
// Directed bench for writeback_multi: one instance with NPORTS=1 and one with
// NPORTS=2, both NLANES=2, DEPTH=2, sharing bundle data and reset.
module tb_writeback_multi;

  localparam int AW = 5;
  localparam int XL = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn;
  logic            in_valid1, in_valid2;
  logic [1:0]      in_slot_valid, in_regwrite;
  logic [2*AW-1:0] in_wa;
  logic [2*XL-1:0] in_result;

  logic            ready1, empty1;
  logic [0:0]      we1;
  logic [AW-1:0]   wa1;
  logic [XL-1:0]   wd1;
  logic [1:0]      ret1;

  logic            ready2, empty2;
  logic [1:0]      we2;
  logic [2*AW-1:0] wa2;
  logic [2*XL-1:0] wd2;
  logic [1:0]      ret2;

`ifdef WB_INSTRET_EN
  logic [63:0] instret1, instret2, instret_snap;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  writeback_multi #(.NLANES(2), .NPORTS(1), .DEPTH(2), .XLEN(XL), .AW(AW)) u_p1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid1), .in_ready(ready1),
    .in_slot_valid(in_slot_valid), .in_regwrite(in_regwrite), .in_wa(in_wa),
    .in_result(in_result), .rf_we(we1), .rf_wa(wa1), .rf_wd(wd1),
    .retire_cnt(ret1),
`ifdef WB_INSTRET_EN
    .instret(instret1),
`endif
    .empty(empty1)
  );

  writeback_multi #(.NLANES(2), .NPORTS(2), .DEPTH(2), .XLEN(XL), .AW(AW)) u_p2 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid2), .in_ready(ready2),
    .in_slot_valid(in_slot_valid), .in_regwrite(in_regwrite), .in_wa(in_wa),
    .in_result(in_result), .rf_we(we2), .rf_wa(wa2), .rf_wd(wd2),
    .retire_cnt(ret2),
`ifdef WB_INSTRET_EN
    .instret(instret2),
`endif
    .empty(empty2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Set bundle data: {slot1, slot0}
  task automatic bundle(input logic [1:0] sv, input logic [1:0] rw,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                        input logic [XL-1:0] d1, input logic [XL-1:0] d0);
    in_slot_valid = sv;
    in_regwrite   = rw;
    in_wa         = {a1, a0};
    in_result     = {d1, d0};
  endtask

  // One expected write on the single-port instance.
  task automatic expect_w1(input string tag, input logic [AW-1:0] a, input logic [XL-1:0] d);
    check({tag, ".we"},  128'(we1),  128'(1'b1));
    check({tag, ".wa"},  128'(wa1),  128'(a));
    check({tag, ".wd"},  128'(wd1),  128'(d));
    check({tag, ".ret"}, 128'(ret1), 128'(2'd1));
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid1 = 1'b1;
    in_valid2 = 1'b1;
    bundle(2'b11, 2'b11, 5'd9, 5'd8, 64'h99, 64'h88);

    // Reset held for two cycles with a bundle offered
    tick();
    tick();
    check("rst.ready1", 128'(ready1), 128'(1'b1));
    check("rst.we1",    128'(we1),    128'(1'b0));
    check("rst.ret1",   128'(ret1),   128'(2'd0));
    check("rst.empty1", 128'(empty1), 128'(1'b1));
    check("rst.ready2", 128'(ready2), 128'(1'b1));
    check("rst.we2",    128'(we2),    128'(2'b00));
    check("rst.empty2", 128'(empty2), 128'(1'b1));
    resetn    = 1'b1;
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
    tick();
    check("post_rst.empty1", 128'(empty1), 128'(1'b1));
    check("post_rst.we1",    128'(we1),    128'(1'b0));
    check("post_rst.empty2", 128'(empty2), 128'(1'b1));

    // Single port: two slots drain over two cycles
    bundle(2'b11, 2'b11, 5'd6, 5'd5, 64'h22, 64'h11);
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    expect_w1("a0", 5'd5, 64'h11);
    check("a0.empty1", 128'(empty1), 128'(1'b0));
    tick();
    expect_w1("a1", 5'd6, 64'h22);
    tick();
    check("a2.empty1", 128'(empty1), 128'(1'b1));
    check("a2.we1",    128'(we1),    128'(1'b0));
    check("a2.ret1",   128'(ret1),   128'(2'd0));

    // Two ports, same destination: only the higher lane writes
    bundle(2'b11, 2'b11, 5'd7, 5'd7, 64'hB, 64'hA);
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    check("b.we2",  128'(we2),          128'(2'b10));
    check("b.wa2",  128'(wa2[2*AW-1:AW]), 128'(5'd7));
    check("b.wd2",  128'(wd2[2*XL-1:XL]), 128'(64'hB));
    check("b.ret2", 128'(ret2),         128'(2'd2));
    tick();
    check("b.empty2", 128'(empty2), 128'(1'b1));

    // x0 and no-write slots still retire
    bundle(2'b11, 2'b01, 5'd3, 5'd0, 64'h33, 64'hFF);
`ifdef WB_INSTRET_EN
    instret_snap = instret2;
`endif
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    check("c.we2",  128'(we2),  128'(2'b00));
    check("c.ret2", 128'(ret2), 128'(2'd2));
    tick();
    check("c.empty2", 128'(empty2), 128'(1'b1));
`ifdef WB_INSTRET_EN
    check("c.instret2", 128'(instret2 - instret_snap), 128'(64'd2));
`endif

    // Bundle with no valid slots: accepted, popped next cycle with no retire
    bundle(2'b00, 2'b11, 5'd2, 5'd1, 64'h2, 64'h1);
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("e.empty1", 128'(empty1), 128'(1'b0));
    check("e.ret1",   128'(ret1),   128'(2'd0));
    check("e.we1",    128'(we1),    128'(1'b0));
    tick();
    check("e.empty1_after", 128'(empty1), 128'(1'b1));

    // Back-pressure: three bundles offered back-to-back into DEPTH=2
    bundle(2'b11, 2'b11, 5'd2, 5'd1, 64'h2, 64'h1);
    in_valid1 = 1'b1;
    check("d.ready_b0", 128'(ready1), 128'(1'b1));
    tick();
    expect_w1("d.w1", 5'd1, 64'h1);
    bundle(2'b11, 2'b11, 5'd4, 5'd3, 64'h4, 64'h3);
    check("d.ready_b1", 128'(ready1), 128'(1'b1));
    tick();
    expect_w1("d.w2", 5'd2, 64'h2);
    bundle(2'b11, 2'b11, 5'd6, 5'd5, 64'h6, 64'h5);
    check("d.ready_b2_full", 128'(ready1), 128'(1'b0));
    tick();
    expect_w1("d.w3", 5'd3, 64'h3);
    check("d.ready_b2_retry", 128'(ready1), 128'(1'b1));
    tick();
    in_valid1 = 1'b0;
    expect_w1("d.w4", 5'd4, 64'h4);
    tick();
    expect_w1("d.w5", 5'd5, 64'h5);
    tick();
    expect_w1("d.w6", 5'd6, 64'h6);
    tick();
    check("d.empty1", 128'(empty1), 128'(1'b1));
    check("d.we1",    128'(we1),    128'(1'b0));

    // Reset in the middle of a drain discards the rest of the bundle
    bundle(2'b11, 2'b11, 5'd9, 5'd8, 64'h90, 64'h80);
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    expect_w1("r.w0", 5'd8, 64'h80);
    resetn = 1'b0;
    tick();
    check("r.we1_rst",    128'(we1),    128'(1'b0));
    check("r.empty1_rst", 128'(empty1), 128'(1'b1));
    resetn = 1'b1;
    tick();
    check("r.we1_after",    128'(we1),    128'(1'b0));
    check("r.ret1_after",   128'(ret1),   128'(2'd0));
    check("r.empty1_after", 128'(empty1), 128'(1'b1));
    tick();
    check("r.we1_late", 128'(we1), 128'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
